// File: rtl/ebr_read_lane_unpacker.sv
// rtl/ebr_read_lane_unpacker.sv - narrow-lane read adapter in front of a wide block RAM read port
//
// Splits a narrow lane address into a RAM word address and a lane select.
// It issues the RAM read in the same cycle it accepts the request. The lane
// and mode are tracked through the RAM latency. On capture, the selected lane
// is unpacked and queued as a right-justified, zero-extended response.
//
// Ports:
//   clk, rst              clock, synchronous active-high reset
//   req_valid/req_ready   request handshake
//   req_mode              lane mode; lane width = WORD_W >> req_mode
//   req_addr              narrow lane address (WA_W+3 bits)
//   ram_re, ram_raddr     RAM read enable and word address
//   ram_rdata             RAM read data, valid RD_LAT cycles after ram_re
//   rsp_valid/rsp_ready   response handshake
//   rsp_data              extracted lane, right-justified, upper bits zero
//   addr_err              sticky out-of-range address flag

module ebr_read_lane_unpacker #(
    parameter int WORD_W = 16,
    parameter int WA_W   = 8,
    parameter int RD_LAT = 1,
    parameter int LAYOUT = 0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic [1:0]        req_mode,
    input  logic [WA_W+2:0]   req_addr,
    output logic              ram_re,
    output logic [WA_W-1:0]   ram_raddr,
    input  logic [WORD_W-1:0] ram_rdata,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [WORD_W-1:0] rsp_data,
    output logic              addr_err
);

    localparam int DEPTH = RD_LAT + 2;
    localparam int PW    = $clog2(DEPTH);
    localparam int CW    = $clog2(DEPTH + 1);
    localparam int IW    = $clog2(WORD_W);

    // Gathers lane l of word w for mode m into the low bits of the result.
    // Interleaved: bit j comes from w[l + j*2^m]; contiguous: from w[l*LW + j].
    function automatic logic [WORD_W-1:0] unpack(input logic [WORD_W-1:0] w,
                                                 input logic [1:0]        m,
                                                 input logic [2:0]        l);
        logic [WORD_W-1:0] r;
        int                lw;
        int                idx;
        r  = '0;
        lw = WORD_W >> m;
        for (int j = 0; j < WORD_W; j++) begin
            if (LAYOUT == 0) begin
                idx = int'(l) + (j << m);
            end else begin
                idx = int'(l) * lw + j;
            end
            if (j < lw && idx < WORD_W) begin
                r[j[IW-1:0]] = w[idx[IW-1:0]];
            end
        end
        return r;
    endfunction

    // Address split
    logic [WA_W+2:0] addr_shift;
    logic            addr_oor;
    logic [2:0]      req_lane;

    assign addr_shift = req_addr >> req_mode;
    assign ram_raddr  = addr_shift[WA_W-1:0];
    assign addr_oor   = |addr_shift[WA_W+2:WA_W];

    always_comb begin
        req_lane = 3'd0;
        case (req_mode)
            2'd0:    req_lane = 3'd0;
            2'd1:    req_lane = {2'b00, req_addr[0]};
            2'd2:    req_lane = {1'b0, req_addr[1:0]};
            default: req_lane = req_addr[2:0];
        endcase
    end

    // Handshakes
    logic [CW-1:0] credits;
    logic [CW-1:0] count;
    logic          accept;
    logic          pop;
    logic          push;

    // Credits cover every slot that is in flight or buffered, so the FIFO
    // cannot overflow even though capture has no backpressure.
    assign req_ready = !rst && (credits < CW'(DEPTH));
    assign accept    = req_valid && req_ready;
    assign ram_re    = accept;
    assign rsp_valid = !rst && (count != '0);
    assign pop       = rsp_valid && rsp_ready;

    always_ff @(posedge clk) begin
        if (rst) begin
            credits <= '0;
        end else begin
            credits <= credits + CW'(accept) - CW'(pop);
        end
    end

    // Latency tracking; only the valid bit needs clearing on reset so that
    // RAM data returning for pre-reset reads is ignored.
    logic       pipe_v    [1:RD_LAT];
    logic [1:0] pipe_mode [1:RD_LAT];
    logic [2:0] pipe_lane [1:RD_LAT];

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int k = 1; k <= RD_LAT; k++) begin
                pipe_v[k] <= 1'b0;
            end
        end else begin
            pipe_v[1] <= accept;
            for (int k = 2; k <= RD_LAT; k++) begin
                pipe_v[k] <= pipe_v[k-1];
            end
        end
    end

    always_ff @(posedge clk) begin
        pipe_mode[1] <= req_mode;
        pipe_lane[1] <= req_lane;
        for (int k = 2; k <= RD_LAT; k++) begin
            pipe_mode[k] <= pipe_mode[k-1];
            pipe_lane[k] <= pipe_lane[k-1];
        end
    end

    logic [WORD_W-1:0] cap_data;

    assign push     = pipe_v[RD_LAT];
    assign cap_data = unpack(ram_rdata, pipe_mode[RD_LAT], pipe_lane[RD_LAT]);

    // Response FIFO
    logic [WORD_W-1:0] fifo_mem [DEPTH];
    logic [PW-1:0]     wr_ptr;
    logic [PW-1:0]     rd_ptr;
    logic [WORD_W-1:0] last_q;

    function automatic logic [PW-1:0] next_ptr(input logic [PW-1:0] p);
        return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
    endfunction

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            last_q <= '0;
        end else begin
            if (push) begin
                wr_ptr <= next_ptr(wr_ptr);
            end
            if (pop) begin
                rd_ptr <= next_ptr(rd_ptr);
                last_q <= fifo_mem[rd_ptr];
            end
            count <= count + CW'(push) - CW'(pop);
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            fifo_mem[wr_ptr] <= cap_data;
        end
    end

    // When the FIFO is empty, the output keeps the value of the last popped
    // entry rather than exposing a stale slot.
    assign rsp_data = rst ? '0 : ((count != '0) ? fifo_mem[rd_ptr] : last_q);

    always_ff @(posedge clk) begin
        if (rst) begin
            addr_err <= 1'b0;
        end else if (accept && addr_oor) begin
            addr_err <= 1'b1;
        end
    end

endmodule

// File: tb/tb_ebr_read_lane_unpacker.sv
// tb/tb_ebr_read_lane_unpacker.sv - self-checking bench for ebr_read_lane_unpacker

module tb_ebr_read_lane_unpacker;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst;
    logic        req_valid [2];
    logic        req_ready [2];
    logic [1:0]  req_mode  [2];
    logic [10:0] req_addr  [2];
    logic        ram_re    [2];
    logic [7:0]  ram_raddr [2];
    logic [15:0] ram_rdata [2];
    logic        rsp_valid [2];
    logic        rsp_ready [2];
    logic [15:0] rsp_data  [2];
    logic        addr_err  [2];

    // Instance 0: RD_LAT=1 interleaved; instance 1: RD_LAT=3 contiguous
    ebr_read_lane_unpacker #(.WORD_W(16), .WA_W(8), .RD_LAT(1), .LAYOUT(0)) u_a (
        .clk(clk), .rst(rst),
        .req_valid(req_valid[0]), .req_ready(req_ready[0]),
        .req_mode(req_mode[0]), .req_addr(req_addr[0]),
        .ram_re(ram_re[0]), .ram_raddr(ram_raddr[0]), .ram_rdata(ram_rdata[0]),
        .rsp_valid(rsp_valid[0]), .rsp_ready(rsp_ready[0]), .rsp_data(rsp_data[0]),
        .addr_err(addr_err[0])
    );

    ebr_read_lane_unpacker #(.WORD_W(16), .WA_W(8), .RD_LAT(3), .LAYOUT(1)) u_b (
        .clk(clk), .rst(rst),
        .req_valid(req_valid[1]), .req_ready(req_ready[1]),
        .req_mode(req_mode[1]), .req_addr(req_addr[1]),
        .ram_re(ram_re[1]), .ram_raddr(ram_raddr[1]), .ram_rdata(ram_rdata[1]),
        .rsp_valid(rsp_valid[1]), .rsp_ready(rsp_ready[1]), .rsp_data(rsp_data[1]),
        .addr_err(addr_err[1])
    );

    // RAM models
    logic [15:0] mem [2][256];
    logic [15:0] rd_a;
    logic [15:0] rd_b [3];

    always @(posedge clk) begin
        rd_a    <= mem[0][ram_raddr[0]];
        rd_b[0] <= mem[1][ram_raddr[1]];
        rd_b[1] <= rd_b[0];
        rd_b[2] <= rd_b[1];
    end
    assign ram_rdata[0] = rd_a;
    assign ram_rdata[1] = rd_b[2];

    // Reference state
    logic [15:0] qa[$];
    logic [15:0] qb[$];
    logic        err_m [2];
    logic        hold  [2];
    logic [15:0] hdata [2];
    int          acc   [2];
    int          pops  [2];
    int          n_vec = 0;
    int          n_err = 0;

    function automatic int depth(input int d);
        return (d == 0) ? 3 : 5;
    endfunction

    function automatic int qsize(input int d);
        return (d == 0) ? qa.size() : qb.size();
    endfunction

    function automatic logic [15:0] ref_unpack(input logic [15:0] w, input int mode,
                                               input int addr, input int layout);
        int lanes, lw, lane, wi, r;
        lanes = 1 << mode;
        lw    = 16 / lanes;
        lane  = addr % lanes;
        wi    = int'(w);
        r     = 0;
        if (layout == 1) begin
            r = (wi >> (lane * lw)) & ((1 << lw) - 1);
        end else begin
            for (int j = 0; j < lw; j++) begin
                r = r | (((wi >> (lane + j * lanes)) & 1) << j);
            end
        end
        return 16'(r);
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // One clock cycle: check handshakes against the model before the edge,
    // then the registered outputs after it.
    task automatic tick();
        logic        was_rst;
        logic        exp_rdy;
        logic [15:0] e;
        int          m, a, ra;
        #1;
        was_rst = rst;
        for (int d = 0; d < 2; d++) begin
            m = int'(req_mode[d]);
            a = int'(req_addr[d]);
            exp_rdy = !rst && (qsize(d) < depth(d));
            chk($sformatf("req_ready%0d", d), 32'(req_ready[d]), 32'(exp_rdy));
            chk($sformatf("ram_re%0d", d), 32'(ram_re[d]), 32'(req_valid[d] && exp_rdy));
            if (req_valid[d] && exp_rdy) begin
                ra = (a >> m) & 255;
                chk($sformatf("ram_raddr%0d", d), 32'(ram_raddr[d]), 32'(ra));
                e = ref_unpack(mem[d][8'(ra)], m, a, d);
                if (d == 0) qa.push_back(e); else qb.push_back(e);
                if ((a >> (8 + m)) != 0) err_m[d] = 1'b1;
                acc[d]++;
            end
            if (rsp_valid[d] && rsp_ready[d]) begin
                e = 16'hxxxx;
                if (d == 0 && qa.size() != 0) e = qa.pop_front();
                if (d == 1 && qb.size() != 0) e = qb.pop_front();
                chk($sformatf("rsp_data%0d", d), 32'(rsp_data[d]), 32'(e));
                pops[d]++;
            end
            hold[d] = rsp_valid[d] && !rsp_ready[d];
            hdata[d] = rsp_data[d];
        end
        @(posedge clk);
        #1;
        for (int d = 0; d < 2; d++) begin
            if (was_rst) begin
                if (d == 0) qa.delete(); else qb.delete();
                err_m[d] = 1'b0;
                hold[d]  = 1'b0;
                chk($sformatf("rst_rsp_valid%0d", d), 32'(rsp_valid[d]), 32'(rst ? 1'b0 : (qsize(d) != 0)));
                chk($sformatf("rst_rsp_data%0d", d), 32'(rsp_data[d]), 32'h0);
            end else if (hold[d]) begin
                chk($sformatf("hold_valid%0d", d), 32'(rsp_valid[d]), 32'h1);
                chk($sformatf("hold_data%0d", d), 32'(rsp_data[d]), 32'(hdata[d]));
            end
            chk($sformatf("addr_err%0d", d), 32'(addr_err[d]), 32'(err_m[d]));
        end
    endtask

    task automatic issue(input int d, input int m, input int a);
        req_valid[d] = 1'b1;
        req_mode[d]  = 2'(m);
        req_addr[d]  = 11'(a);
        tick();
        req_valid[d] = 1'b0;
    endtask

    function automatic int in_range_addr(input int m);
        return int'($urandom_range(0, (256 << m) - 1));
    endfunction

    initial begin
        int base, base_p, m;
        rst = 1'b1;
        for (int d = 0; d < 2; d++) begin
            req_valid[d] = 1'b1;
            req_mode[d]  = 2'd0;
            req_addr[d]  = 11'd0;
            rsp_ready[d] = 1'b1;
            err_m[d]     = 1'b0;
            hold[d]      = 1'b0;
            acc[d]       = 0;
            pops[d]      = 0;
        end
        for (int i = 0; i < 256; i++) begin
            mem[0][i] = 16'($urandom);
            mem[1][i] = 16'($urandom);
        end

        // Reset state, with requests offered during reset
        tick();
        tick();
        req_valid[0] = 1'b0;
        req_valid[1] = 1'b0;
        rst = 1'b0;
        tick();

        // Full word, first-response latency
        mem[0][8'h12] = 16'hA5C3;
        issue(0, 0, 'h012);
        chk("lat_early", 32'(rsp_valid[0]), 32'h0);
        tick();
        chk("lat_valid", 32'(rsp_valid[0]), 32'h1);
        chk("t_mode0", 32'(rsp_data[0]), 32'hA5C3);
        tick();

        // Mode 1, odd lane
        mem[0][8'h02] = 16'hA5C3;
        issue(0, 1, 'h005);
        tick();
        chk("t_mode1", 32'(rsp_data[0]), 32'h00C9);
        tick();

        // Mode 3, top address, both layouts
        mem[0][8'hFF] = 16'h8080;
        mem[1][8'hFF] = 16'hC000;
        req_valid[0] = 1'b1; req_mode[0] = 2'd3; req_addr[0] = 11'h7FF;
        req_valid[1] = 1'b1; req_mode[1] = 2'd3; req_addr[1] = 11'h7FF;
        tick();
        req_valid[0] = 1'b0;
        req_valid[1] = 1'b0;
        tick();
        chk("t_mode3_il", 32'(rsp_data[0]), 32'h0003);
        tick();
        chk("t_lat3_early", 32'(rsp_valid[1]), 32'h0);
        tick();
        chk("t_lat3_valid", 32'(rsp_valid[1]), 32'h1);
        chk("t_mode3_ct", 32'(rsp_data[1]), 32'h0003);
        tick();

        // Backpressure: credits limit outstanding requests to DEPTH
        rsp_ready[0] = 1'b0;
        req_valid[0] = 1'b1;
        base = acc[0];
        repeat (6) begin
            m = int'($urandom_range(0, 3));
            req_mode[0] = 2'(m);
            req_addr[0] = 11'(in_range_addr(m));
            tick();
        end
        chk("bp_accepts", 32'(acc[0] - base), 32'd3);
        chk("bp_ready_low", 32'(req_ready[0]), 32'h0);
        chk("bp_valid", 32'(rsp_valid[0]), 32'h1);
        req_valid[0] = 1'b0;
        rsp_ready[0] = 1'b1;
        base_p = pops[0];
        tick();
        chk("bp_ready_back", 32'(req_ready[0]), 32'h1);
        tick();
        tick();
        chk("bp_pops", 32'(pops[0] - base_p), 32'd3);
        chk("bp_empty", 32'(rsp_valid[0]), 32'h0);

        // Back-to-back mode changes at full throughput (RD_LAT=3)
        base   = acc[1];
        base_p = pops[1];
        req_valid[1] = 1'b1;
        for (int i = 0; i < 9; i++) begin
            m = (i % 3 == 0) ? 0 : ((i % 3 == 1) ? 2 : 1);
            req_mode[1] = 2'(m);
            req_addr[1] = 11'(in_range_addr(m));
            tick();
        end
        req_valid[1] = 1'b0;
        chk("alt_accepts", 32'(acc[1] - base), 32'd9);
        chk("alt_pops_mid", 32'(pops[1] - base_p), 32'd5);
        repeat (4) tick();
        chk("alt_pops_end", 32'(pops[1] - base_p), 32'd9);

        // Out-of-range address: flag is sticky and the read still issues
        issue(0, 0, 'h100);
        chk("err_set", 32'(addr_err[0]), 32'h1);
        repeat (3) tick();
        chk("err_sticky", 32'(addr_err[0]), 32'h1);

        // Reset with requests in flight: nothing stale may emerge
        for (int d = 0; d < 2; d++) begin
            req_valid[d] = 1'b1;
            req_mode[d]  = 2'd0;
            req_addr[d]  = 11'h011;
        end
        tick();
        req_addr[0] = 11'h022;
        req_addr[1] = 11'h022;
        tick();
        req_valid[0] = 1'b0;
        req_valid[1] = 1'b0;
        rst = 1'b1;
        tick();
        rst = 1'b0;
        for (int i = 0; i < 6; i++) begin
            tick();
            chk("post_rst_valid0", 32'(rsp_valid[0]), 32'h0);
            chk("post_rst_valid1", 32'(rsp_valid[1]), 32'h0);
        end
        chk("post_rst_err", 32'(addr_err[0]), 32'h0);

        // Randomised traffic with random backpressure on both instances
        for (int i = 0; i < 400; i++) begin
            for (int d = 0; d < 2; d++) begin
                m = int'($urandom_range(0, 3));
                req_valid[d] = ($urandom_range(0, 99) < 70);
                req_mode[d]  = 2'(m);
                req_addr[d]  = ($urandom_range(0, 15) == 0) ? 11'($urandom) : 11'(in_range_addr(m));
                rsp_ready[d] = ($urandom_range(0, 99) < 60);
            end
            tick();
        end
        for (int d = 0; d < 2; d++) begin
            req_valid[d] = 1'b0;
            rsp_ready[d] = 1'b1;
        end
        repeat (10) tick();
        chk("drain_a", 32'(qa.size()), 32'd0);
        chk("drain_b", 32'(qb.size()), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
